// File: rtl/mem_instr_sequencer.sv
// mem_instr_sequencer: fetch + ld/ldi/st control sequencer for the single-bus dataPath
// Ports: clk, reset (sync, active-high), start, opcode (IR[31:27]), mem_ready in;
//   dataPath strobes (PCout..write), mdr_read (00 bus, 01 memory), control (ALU op),
//   busy, done (1-cycle pulse), illegal (sticky), timeout (sticky) out.
// Build option: SEQ_TIMEOUT_EN adds a memory wait limit of WAIT_MAX cycles.
module mem_instr_sequencer #(
  parameter int OP_W = 5,
  parameter int CTRL_W = 4,
  parameter logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(2),
  parameter logic [OP_W-1:0] OP_LD = OP_W'(0),
  parameter logic [OP_W-1:0] OP_LDI = OP_W'(1),
  parameter logic [OP_W-1:0] OP_ST = OP_W'(2),
  parameter int WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic              mem_ready,
  output logic              PCout,
  output logic              Zlowout,
  output logic              MDRout,
  output logic              MARin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              IncPc,
  output logic              Zlowin,
  output logic              GRA,
  output logic              GRB,
  output logic              GRC,
  output logic              BAout,
  output logic              Rin,
  output logic              Rout,
  output logic              Cout,
  output logic              read,
  output logic              write,
  output logic [1:0]        mdr_read,
  output logic [CTRL_W-1:0] control,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              timeout
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE, ERR} state_t;
  state_t st_q, st_d;
  logic [OP_W-1:0] op_q, op_d;
  logic illegal_q, illegal_d;
  logic is_ld, is_ldi, is_st, mem_rd;
  assign is_ld = op_q == OP_LD;
  assign is_ldi = op_q == OP_LDI;
  assign is_st = op_q == OP_ST;
  assign mem_rd = st_q == T1 || (st_q == T6 && is_ld);
  assign PCout = st_q == T0;
  assign Zlowout = st_q == T1 || st_q == T5;
  assign MDRout = st_q == T2 || (st_q == T7 && is_ld);
  assign MARin = st_q == T0 || (st_q == T5 && !is_ldi);
  assign PCin = st_q == T1;
  assign MDRin = st_q == T1 || st_q == T6;
  assign IRin = st_q == T2;
  assign Yin = st_q == T3;
  assign IncPc = st_q == T0;
  assign Zlowin = st_q == T0 || st_q == T4;
  assign GRA = (st_q == T5 && is_ldi) || (st_q == T6 && is_st) || (st_q == T7 && is_ld);
  assign GRB = st_q == T3;
  assign GRC = 1'b0;
  assign BAout = st_q == T3;
  assign Rin = (st_q == T5 && is_ldi) || (st_q == T7 && is_ld);
  assign Rout = st_q == T6 && is_st;
  assign Cout = st_q == T4;
  assign read = mem_rd;
  assign write = st_q == T7 && is_st;
  assign mdr_read = {1'b0, mem_rd};
  assign control = st_q == T4 ? ALU_ADD : '0;
  assign busy = st_q != IDLE;
  assign done = st_q == DONE;
  assign illegal = illegal_q;
`ifdef SEQ_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic [7:0] wait_q, wait_d;
  logic waiting;
  assign waiting = !mem_ready && (st_q == T1 || (st_q == T6 && is_ld) || (st_q == T7 && is_st));
  assign timeout = timeout_q;
`else
  logic unused_wait_max;
  assign unused_wait_max = |WAIT_MAX;
  assign timeout = 1'b0;
`endif
  always_comb begin
    st_d = st_q;
    op_d = op_q;
    illegal_d = illegal_q;
    case (st_q)
      IDLE: st_d = start ? T0 : IDLE;
      T0:   st_d = T1;
      T1:   st_d = mem_ready ? T2 : T1;
      T2:   st_d = T3;
      T3: begin
        op_d = opcode;
        if (opcode == OP_LD || opcode == OP_LDI || opcode == OP_ST) st_d = T4;
        else begin
          st_d = ERR;
          illegal_d = 1'b1;
        end
      end
      T4:   st_d = T5;
      T5:   st_d = is_ldi ? DONE : T6;
      T6:   st_d = (is_ld && !mem_ready) ? T6 : T7;
      T7:   st_d = (is_st && !mem_ready) ? T7 : DONE;
      DONE: st_d = IDLE;
      ERR:  st_d = ERR;
      default: st_d = IDLE;
    endcase
`ifdef SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
    wait_d = waiting ? wait_q + 8'd1 : 8'd0;
    if (waiting && wait_q + 8'd1 == 8'(WAIT_MAX)) begin
      st_d = ERR;
      timeout_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      op_q <= '0;
      illegal_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
      wait_q <= 8'd0;
`endif
    end else begin
      st_q <= st_d;
      op_q <= op_d;
      illegal_q <= illegal_d;
`ifdef SEQ_TIMEOUT_EN
      timeout_q <= timeout_d;
      wait_q <= wait_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_instr_sequencer.sv
// tb_mem_instr_sequencer: randomized check of the sequencer against a per-instruction trace model
module tb_mem_instr_sequencer;
  typedef struct packed {
    logic PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPc, Zlowin;
    logic GRA, GRB, GRC, BAout, Rin, Rout, Cout, read, write;
    logic [1:0] mdr_read;
    logic [3:0] control;
    logic busy, done, illegal, timeout;
  } ctl_t;
  logic clk = 0, reset = 1, start = 0, mem_ready = 0;
  logic [4:0] opcode = 0;
  logic PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPc, Zlowin;
  logic GRA, GRB, GRC, BAout, Rin, Rout, Cout, read, write;
  logic [1:0] mdr_read;
  logic [3:0] control;
  logic busy, done, illegal, timeout;
  ctl_t obs;
  ctl_t eq[$];
  bit mq[$];
  int checks = 0, failures = 0;
  mem_instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPc(IncPc), .Zlowin(Zlowin),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .BAout(BAout), .Rin(Rin), .Rout(Rout),
    .Cout(Cout), .read(read), .write(write), .mdr_read(mdr_read), .control(control),
    .busy(busy), .done(done), .illegal(illegal), .timeout(timeout)
  );
  assign obs = {PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPc, Zlowin,
                GRA, GRB, GRC, BAout, Rin, Rout, Cout, read, write, mdr_read, control,
                busy, done, illegal, timeout};
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic add(ctl_t c, int zeros, bit ws);
    repeat (zeros) begin
      eq.push_back(c);
      mq.push_back(1'b0);
    end
    eq.push_back(c);
    mq.push_back(ws ? 1'b1 : 1'($urandom));
  endtask
  task automatic err(bit ill, bit tmo);
    ctl_t c = '0;
    c.busy = 1; c.illegal = ill; c.timeout = tmo;
    repeat (4) add(c, 0, 0);
  endtask
  task automatic build(logic [4:0] op, int w1, int w2, bit tmo);
    ctl_t c;
    eq.delete();
    mq.delete();
    c = '0; c.busy = 1; c.PCout = 1; c.MARin = 1; c.IncPc = 1; c.Zlowin = 1;
    add(c, 0, 0);
    c = '0; c.busy = 1; c.Zlowout = 1; c.PCin = 1; c.read = 1; c.MDRin = 1; c.mdr_read = 2'b01;
    if (tmo) begin
      repeat (8) begin
        eq.push_back(c);
        mq.push_back(1'b0);
      end
      err(0, 1);
      return;
    end
    add(c, w1, 1);
    c = '0; c.busy = 1; c.MDRout = 1; c.IRin = 1;
    add(c, 0, 0);
    c = '0; c.busy = 1; c.GRB = 1; c.BAout = 1; c.Yin = 1;
    add(c, 0, 0);
    if (op > 2) begin
      err(1, 0);
      return;
    end
    c = '0; c.busy = 1; c.Cout = 1; c.Zlowin = 1; c.control = 4'd2;
    add(c, 0, 0);
    c = '0; c.busy = 1; c.Zlowout = 1;
    if (op == 1) begin c.GRA = 1; c.Rin = 1; end else c.MARin = 1;
    add(c, 0, 0);
    if (op == 0) begin
      c = '0; c.busy = 1; c.read = 1; c.MDRin = 1; c.mdr_read = 2'b01;
      add(c, w2, 1);
      c = '0; c.busy = 1; c.MDRout = 1; c.GRA = 1; c.Rin = 1;
      add(c, 0, 0);
    end else if (op == 2) begin
      c = '0; c.busy = 1; c.GRA = 1; c.Rout = 1; c.MDRin = 1;
      add(c, 0, 0);
      c = '0; c.busy = 1; c.write = 1;
      add(c, w2, 1);
    end
    c = '0; c.busy = 1; c.done = 1;
    add(c, 0, 0);
    add('0, 0, 0);
  endtask
  task automatic run(string tag, logic [4:0] op, int rst_at);
    opcode = op;
    start = 1;
    mem_ready = 1'($urandom);
    @(posedge clk); #1;
    for (int k = 0; k < eq.size(); k++) begin
      chk($sformatf("%s_c%0d", tag, k), 32'(obs), 32'(eq[k]));
      if (k == eq.size() - 1 || k == rst_at) break;
      mem_ready = mq[k];
      start = eq[k].busy ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
    end
    if (rst_at >= 0 || eq[eq.size()-1].busy) begin
      reset = 1;
      start = 1'($urandom);
      mem_ready = 1'($urandom);
      @(posedge clk); #1;
      chk({tag, "_rst"}, 32'(obs), 32'(0));
      reset = 0;
    end
    start = 0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'(obs), 32'(0));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'(obs), 32'(0));
    reset = 0;
    @(posedge clk); #1;
    chk("idle_nostart", 32'(obs), 32'(0));
    build(5'd0, 0, 0, 0); run("ld", 5'd0, -1);
    chk("ld_len", 32'(eq.size() - 1), 32'd9);
    build(5'd1, 0, 0, 0); run("ldi", 5'd1, -1);
    chk("ldi_len", 32'(eq.size() - 1), 32'd7);
    build(5'd2, 0, 3, 0); run("st_wait", 5'd2, -1);
    chk("st_len", 32'(eq.size() - 1), 32'd12);
    build(5'd9, 0, 0, 0); run("illegal", 5'd9, -1);
    build(5'd0, 0, 0, 0); run("ld_rst_t6", 5'd0, 6);
    build(5'd0, 1, 2, 0); run("ld_after_rst", 5'd0, -1);
`ifdef SEQ_TIMEOUT_EN
    build(5'd0, 0, 0, 1); run("timeout", 5'd0, -1);
    build(5'd2, 7, 7, 0); run("st_w7", 5'd2, -1);
`else
    build(5'd0, 12, 0, 0); run("long_wait", 5'd0, -1);
`endif
    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      int rst_at;
      op = $urandom_range(0, 3) == 3 ? 5'($urandom_range(3, 31)) : 5'($urandom_range(0, 2));
      build(op, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      rst_at = $urandom_range(0, 7) == 0 ? $urandom_range(0, eq.size() - 1) : -1;
      run($sformatf("rnd%0d", n), op, rst_at);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
